// File: rtl/kernel_memory.sv
// Kernel-weight buffer: one write stream pointer, one first-word-fall-through read pointer,
// both reloadable, over a single-clock RAM of GROUP_NB packed kernel values per word.
module kernel_memory #(
    parameter int unsigned GROUP_NB   = 4,
    parameter int unsigned KER_WIDTH  = 16,
    parameter int unsigned MEM_AWIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MEM_AWIDTH-1:0]           wr_addr,
    input  logic                            wr_addr_set,
    input  logic [GROUP_NB*KER_WIDTH-1:0]   wr_data,
    input  logic                            wr_data_val,
    output logic                            wr_data_rdy,
    input  logic [MEM_AWIDTH-1:0]           rd_addr,
    input  logic                            rd_addr_set,
    output logic [GROUP_NB*KER_WIDTH-1:0]   rd_data,
    input  logic                            rd_data_pop
);
    localparam int unsigned DW    = GROUP_NB * KER_WIDTH;
    localparam int unsigned DEPTH = 2 ** MEM_AWIDTH;

    logic [DW-1:0]         mem [DEPTH];
    logic [MEM_AWIDTH-1:0] wr_ptr;
    logic [MEM_AWIDTH-1:0] rd_ptr;
    logic [MEM_AWIDTH-1:0] rd_ptr_next;
    logic                  rdy_q;
    logic                  wr_en;

    // A pointer reload blocks the stream for that cycle so no word lands at a stale address.
    assign wr_data_rdy = rdy_q & ~wr_addr_set;
    assign wr_en       = wr_data_val & wr_data_rdy;

    always_comb begin
        rd_ptr_next = rd_ptr;
        if (rd_addr_set) begin
            rd_ptr_next = rd_addr;
        end else if (rd_data_pop) begin
            rd_ptr_next = rd_ptr + MEM_AWIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q  <= 1'b0;
            wr_ptr <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (wr_addr_set) begin
                wr_ptr <= wr_addr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + MEM_AWIDTH'(1);
            end
        end
    end

    // RAM is not reset; wr_en is already low throughout reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Reading at the post-edge pointer keeps rd_data aligned with rd_ptr; collisions read old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            rd_ptr  <= rd_ptr_next;
            rd_data <= mem[rd_ptr_next];
        end
    end
endmodule

// File: tb/tb_kernel_memory.sv
// Self-checking bench for kernel_memory: vector table plus reset corner sequences,
// with rd_data expectations queued at drive time and retired after the clock edge.
module tb_kernel_memory;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_addr_set = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_data_val = 1'b0;
    logic          wr_data_rdy;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_addr_set = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_data_pop = 1'b0;

    int total = 0;
    int bad   = 0;

    kernel_memory #(.GROUP_NB(4), .KER_WIDTH(16), .MEM_AWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_addr_set(wr_addr_set),
        .wr_data(wr_data), .wr_data_val(wr_data_val), .wr_data_rdy(wr_data_rdy),
        .rd_addr(rd_addr), .rd_addr_set(rd_addr_set),
        .rd_data(rd_data), .rd_data_pop(rd_data_pop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ws;
        logic [AW-1:0] wa;
        logic          wv;
        logic [DW-1:0] wd;
        logic          rs;
        logic [AW-1:0] ra;
        logic          pop;
        logic          chk;
        logic [DW-1:0] exp_rd;
        logic          exp_rdy;
    } vec_t;

    typedef struct {
        logic          chk;
        logic [DW-1:0] val;
        int            id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    localparam logic [DW-1:0] WA = 64'hAAAA_1111_2222_00FF;
    localparam logic [DW-1:0] WB = 64'hBBBB_3333_4444_0000;
    localparam logic [DW-1:0] WC = 64'hCCCC_5555_6666_0001;
    localparam logic [DW-1:0] WD = 64'hDDDD_7777_8888_0002;
    localparam logic [DW-1:0] WE = 64'hEEEE_9999_AAAA_0003;
    localparam logic [DW-1:0] WF = 64'hFFFF_0000_BBBB_0004;
    localparam logic [DW-1:0] WG = 64'h1234_5678_9ABC_DEF0;

    function automatic vec_t mk(logic ws, logic [AW-1:0] wa, logic wv, logic [DW-1:0] wd,
                                logic rs, logic [AW-1:0] ra, logic pop,
                                logic chk, logic [DW-1:0] exp_rd, logic exp_rdy);
        vec_t v;
        v.ws = ws; v.wa = wa; v.wv = wv; v.wd = wd;
        v.rs = rs; v.ra = ra; v.pop = pop;
        v.chk = chk; v.exp_rd = exp_rd; v.exp_rdy = exp_rdy;
        return v;
    endfunction

    task automatic check_bit(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_word(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational ready, queue the post-edge rd_data.
    task automatic apply(vec_t v, int id);
        exp_t e;
        @(negedge clk);
        wr_addr_set = v.ws; wr_addr = v.wa; wr_data_val = v.wv; wr_data = v.wd;
        rd_addr_set = v.rs; rd_addr = v.ra; rd_data_pop = v.pop;
        #1;
        check_bit($sformatf("rdy[%0d]", id), wr_data_rdy, v.exp_rdy);
        e.chk = v.chk; e.val = v.exp_rd; e.id = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard[%0d]: queue empty, expected one entry", id);
        end else begin
            e = sb.pop_front();
            if (e.chk) check_word($sformatf("rd_data[%0d]", e.id), rd_data, e.val);
        end
    endtask

    task automatic idle_inputs();
        wr_addr_set = 1'b0; wr_data_val = 1'b0; rd_addr_set = 1'b0; rd_data_pop = 1'b0;
    endtask

    initial begin
        // Table: pointer sets, sequential fill, FWFT reads, set-vs-pop, wrap, collision.
        tbl.push_back(mk(1, 8'd0, 0, '0, 1, 8'd0, 0, 0, '0, 0));
        for (int i = 1; i <= 10; i++)
            tbl.push_back(mk(0, 8'd0, 1, DW'(i), 0, 8'd0, 0, (i > 1), 64'd1, 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 0, 8'd0, 0, 1, 64'd1, 1));
        for (int i = 2; i <= 10; i++)
            tbl.push_back(mk(0, 8'd0, 0, '0, 0, 8'd0, 1, 1, DW'(i), 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 0, 8'd0, 1, 0, '0, 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 1, 8'd5, 1, 1, 64'd6, 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 0, 8'd0, 1, 1, 64'd7, 1));
        tbl.push_back(mk(1, 8'd255, 1, 64'hDEAD, 0, 8'd0, 0, 1, 64'd7, 0));
        tbl.push_back(mk(0, 8'd0, 1, WA, 0, 8'd0, 0, 1, 64'd7, 1));
        tbl.push_back(mk(0, 8'd0, 1, WB, 0, 8'd0, 0, 1, 64'd7, 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 1, 8'd255, 0, 1, WA, 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 0, 8'd0, 1, 1, WB, 1));
        tbl.push_back(mk(0, 8'd0, 1, WC, 0, 8'd0, 0, 1, WB, 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 1, 8'd1, 0, 1, WC, 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 1, 8'd2, 0, 1, 64'd3, 1));
        tbl.push_back(mk(0, 8'd0, 1, WD, 0, 8'd0, 0, 1, 64'd3, 1));
        tbl.push_back(mk(0, 8'd0, 0, '0, 0, 8'd0, 0, 1, WD, 1));
        tbl.push_back(mk(0, 8'd0, 1, WE, 0, 8'd0, 0, 1, WD, 1));

        // Reset held with sets and data active: reset must win.
        rst = 1'b0;
        wr_addr_set = 1'b1; wr_addr = 8'd7; rd_addr_set = 1'b1; rd_addr = 8'd3;
        wr_data_val = 1'b1; wr_data = 64'h55;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1 || i == 5) begin
                check_word($sformatf("reset_rd_data[%0d]", i), rd_data, '0);
                check_bit($sformatf("reset_rdy[%0d]", i), wr_data_rdy, 1'b0);
            end
        end
        rst = 1'b1;
        idle_inputs();
        #1;
        check_bit("rdy_before_first_edge", wr_data_rdy, 1'b0);
        @(posedge clk);
        #1;
        check_bit("rdy_after_first_edge", wr_data_rdy, 1'b1);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Asynchronous reset mid-cycle while a write is offered: outputs clear without an edge.
        @(negedge clk);
        wr_data_val = 1'b1; wr_data = WF;
        #2 rst = 1'b0;
        #1;
        check_word("async_reset_rd_data", rd_data, '0);
        check_bit("async_reset_rdy", wr_data_rdy, 1'b0);
        repeat (2) @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);

        // Completed writes survive the reset; write pointer restarts at 0.
        apply(mk(0, 8'd0, 0, '0, 1, 8'd3, 0, 1, WE, 1), 100);
        apply(mk(0, 8'd0, 0, '0, 1, 8'd2, 0, 1, WD, 1), 101);
        apply(mk(0, 8'd0, 0, '0, 1, 8'd255, 0, 1, WA, 1), 102);
        apply(mk(0, 8'd0, 1, WG, 0, 8'd0, 0, 1, WA, 1), 103);
        apply(mk(0, 8'd0, 0, '0, 1, 8'd0, 0, 1, WG, 1), 104);
        apply(mk(0, 8'd0, 0, '0, 0, 8'd0, 1, 1, WC, 1), 105);

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
